// File: rtl/lock_one.sv
// lock_one: sequence-detecting key gate.
//
// One 2-bit symbol {inp0,inp1} is consumed on each rising clk edge:
//   01 = A, 10 = B  : key symbols
//   00              : idle, state held, nothing consumed
//   11              : illegal, lock returns to RST
// The key is A B A B A A. After the edge that samples its last symbol, unlock
// goes high. It stays high through idle symbols and drops on the edge that
// samples the next A, B or 11.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset (0 = reset)
//   inp0   in   symbol bit, MSB
//   inp1   in   symbol bit, LSB
//   unlock out  registered, high only while the lock is in state UNLOCKED
//
// There is no handshake. A symbol is taken on every edge where rst=1, and
// unlock is valid from the register with no combinational input path.
// Checkers can observe the FSM through the internal signal 'state'.
module lock_one (
  input  logic clk,
  input  logic rst,
  input  logic inp0,
  input  logic inp1,
  output logic unlock
);

  // S1..S5 mean "first N key symbols matched". Encoding 3'd7 is unused.
  typedef enum logic [2:0] {
    RST      = 3'd0,
    S1       = 3'd1,
    S2       = 3'd2,
    S3       = 3'd3,
    S4       = 3'd4,
    S5       = 3'd5,
    UNLOCKED = 3'd6
  } state_t;

  state_t     state;
  state_t     next_state;
  state_t     on_a;
  state_t     on_b;
  logic       state_valid;
  logic [1:0] sym;

  assign sym = {inp0, inp1};

  // The fallback targets come from the longest key prefix that is still a
  // suffix of the consumed history. With these targets, overlapping attempts
  // such as ...A B A B A B A A still unlock.
  always_comb begin
    on_a        = RST;
    on_b        = RST;
    state_valid = 1'b1;
    case (state)
      RST:      begin on_a = S1;       on_b = RST; end
      S1:       begin on_a = S1;       on_b = S2;  end
      S2:       begin on_a = S3;       on_b = RST; end
      S3:       begin on_a = S1;       on_b = S4;  end
      S4:       begin on_a = S5;       on_b = RST; end
      S5:       begin on_a = UNLOCKED; on_b = S4;  end
      UNLOCKED: begin on_a = S1;       on_b = S2;  end
      default:  state_valid = 1'b0;
    endcase
  end

  always_comb begin
    next_state = RST;
    if (!state_valid) begin
      // An unused encoding recovers on the next edge, even on an idle symbol.
      next_state = RST;
    end else begin
      case (sym)
        2'b00:   next_state = state;
        2'b01:   next_state = on_a;
        2'b10:   next_state = on_b;
        default: next_state = RST;
      endcase
    end
  end

  // unlock is registered in parallel with state, so it equals
  // (state == UNLOCKED) at every point and never glitches from the inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RST;
      unlock <= 1'b0;
    end else begin
      state  <= next_state;
      unlock <= (next_state == UNLOCKED);
    end
  end

endmodule

// File: tb/tb_lock_one.sv
// Bench for lock_one. Directed sequences carry hand-derived expected unlock
// values. A random phase compares the lock against a history model: unlock
// is high iff the last six consumed symbols since the last reset or 11 spell
// A B A B A A.
module tb_lock_one;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inp0 = 1'b0;
  logic inp1 = 1'b0;
  logic unlock;

  lock_one dut (
    .clk    (clk),
    .rst    (rst),
    .inp0   (inp0),
    .inp1   (inp1),
    .unlock (unlock)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [0:0] exp_q[$];
  logic [1:0] hist[$];
  logic       unl_m = 1'b0;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: unlock=%0b expected=%0b at %0t", tag, obs, exp, $time);
  endtask

  // Drive one symbol at the falling edge and queue its expected result.
  // Then sample 1 time unit after the rising edge that consumes it.
  task automatic step(input string tag, input logic [1:0] sym, input logic exp);
    logic [0:0] e;
    @(negedge clk);
    {inp0, inp1} = sym;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, unlock, ~unlock);
    end else begin
      e = exp_q.pop_front();
      check(tag, unlock, e[0]);
    end
  endtask

  // syms holds n symbols, first one in the most significant used position.
  // exps holds n expected bits in the same order.
  task automatic run_seq(input string tag, input logic [35:0] syms, input int n,
                         input logic [17:0] exps);
    for (int i = 0; i < n; i++)
      step(tag, syms[2*(n-1-i) +: 2], exps[n-1-i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    {inp0, inp1} = 2'b11;
    #2 check("reset_async", unlock, 1'b0);
    @(posedge clk);
    #1 check("reset_hold", unlock, 1'b0);
    @(negedge clk);
    {inp0, inp1} = 2'b00;
    rst = 1'b1;
    hist.delete();
    unl_m = 1'b0;
  endtask

  // Pulse reset between edges and check that unlock falls without a clock.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    {inp0, inp1} = 2'b00;
    #2 rst = 1'b0;
    #1 check(tag, unlock, 1'b0);
    #1 rst = 1'b1;
    hist.delete();
    unl_m = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] sym);
    case (sym)
      2'b00: ;
      2'b11: begin hist.delete(); unl_m = 1'b0; end
      default: begin
        hist.push_back(sym);
        if (hist.size() > 6) void'(hist.pop_front());
        unl_m = (hist.size() == 6) && hist[0] == 2'b01 && hist[1] == 2'b10 &&
                hist[2] == 2'b01 && hist[3] == 2'b10 && hist[4] == 2'b01 &&
                hist[5] == 2'b01;
      end
    endcase
    step("random", sym, unl_m);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1: reset with arbitrary inputs, then idle after release.
    #1 rst = 1'b0;
    #1 check("reset_initial", unlock, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {inp0, inp1} = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1 check("reset_arbitrary_in", unlock, 1'b0);
    end
    @(negedge clk);
    {inp0, inp1} = 2'b00;
    rst = 1'b1;
    run_seq("idle_after_reset", 36'b00_00_00_00_00, 5, 18'b00000);

    // 2: key, hold through idles, fall on B.
    run_seq("key_hold_fall", 36'b01_10_01_10_01_01_00_00_00_10, 10,
            18'b0000011110);

    // 3: key with idle gaps.
    do_reset();
    run_seq("idle_gaps", 36'b01_00_10_00_01_00_10_00_01_00_01, 11,
            18'b00000000001);

    // 4: overlap paths.
    do_reset();
    run_seq("overlap_s5_b", 36'b01_10_01_10_01_10_01_01, 8, 18'b00000001);
    do_reset();
    run_seq("overlap_s1_a", 36'b01_01_10_01_10_01_01, 7, 18'b0000001);

    // 5: errors.
    do_reset();
    run_seq("illegal_11", 36'b01_10_11_01_10_01_01, 7, 18'b0000000);
    do_reset();
    run_seq("bad_b_restart", 36'b01_10_10_01_10_01_10_01_01, 9, 18'b000000001);

    // 6: async reset while unlocked, then at S4.
    do_reset();
    run_seq("pre_async", 36'b01_10_01_10_01_01, 6, 18'b000001);
    pulse_reset("async_unlocked");
    step("after_async", 2'b00, 1'b0);
    run_seq("to_s4", 36'b01_10_01_10, 4, 18'b0000);
    pulse_reset("async_s4");
    run_seq("s4_reset_tail", 36'b01_01, 2, 18'b00);
    run_seq("s4_full_key", 36'b01_10_01_10_01_01, 6, 18'b000001);

    // Random phase against the history model.
    do_reset();
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        model_step(2'b01); model_step(2'b10); model_step(2'b01);
        model_step(2'b10); model_step(2'b01); model_step(2'b01);
      end else begin
        case ($urandom_range(0, 19))
          0, 1, 2, 3, 4, 5, 6, 7:        model_step(2'b01);
          8, 9, 10, 11, 12, 13, 14:      model_step(2'b10);
          15, 16, 17:                    model_step(2'b00);
          default:                       model_step(2'b11);
        endcase
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety bound in case the run stalls.
  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, %0d/%0d done", n_pass, n_checks);
    $fatal(1);
  end

endmodule
